mdr_result_buffer: RTL and testbench
====================================

# mdr_result_buffer

Output-side holding buffer of the multiply/divide/root (MDR) unit. It captures each finished result from the MDR datapath, which is the counterpart to the operand-side load registers. It queues up to two results in a first-word-fall-through buffer and presents them to the downstream consumer over a valid/ready handshake. It raises backpressure to the MDR control when both slots are occupied, so no result is lost. A sticky flag records any load attempted while the buffer was full.

## Interface
Parameters (all in `pkg_system_mdr`, none on the module):
- DW, 16, operand width; `data_in_t` = DW bits
- `result_t`, –, 2*DW-bit product/quotient/root field
- BUF_DEPTH, 2, number of result slots (fixed)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous flush: empties buffer, clears overflow flag
- i_load  in  1  single-cycle pulse from MDR control: result valid on the inputs this cycle
- i_result  in  `result_t`  result value
- i_remainder  in  `data_in_t`  remainder (divide/root); zero for multiply
- i_error  in  1  operation error (divide-by-zero, invalid root)
- o_full  out  1  both slots occupied; MDR control must hold off i_load
- o_valid  out  1  head entry available to consumer
- i_ready  in  1  consumer accepts head this cycle
- o_result  out  `result_t`  head result
- o_remainder  out  `data_in_t`  head remainder
- o_error  out  1  head error flag
- o_count  out  2  occupancy 0..2
- o_overflow  out  1  sticky: a load arrived while full and was not absorbed by a same-cycle pop

## Operation
- Storage: two entries {result, remainder, error}, write pointer and read pointer of 1 bit each, plus a count. The state is EMPTY (count 0), ONE (count 1) or FULL (count 2).
- Push = i_load & (~o_full | pop). Pop = o_valid & i_ready.
- Transitions:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to FULL; pop only goes to EMPTY; push+pop stays in ONE.
  - FULL: pop goes to ONE; push+pop stays in FULL.
  - FULL with i_load and no pop: the data is dropped, o_overflow is set, and the state stays FULL.
- Pointers wrap modulo 2. Stored data is never modified after push.
- Outputs come from the head entry (read pointer). o_valid = (count != 0). o_full = (count == 2). o_count = count.
- o_result, o_remainder and o_error are undefined-but-stable (hold last head) while o_valid = 0. They must not glitch while o_valid = 1 and i_ready = 0.
- i_clear has priority over push and pop in the same cycle. The next state is EMPTY, pointers return to 0 and o_overflow is cleared. Entry storage is not required to be zeroed.
- An i_error entry is buffered and delivered like any other. The buffer does not interpret its value.

## Timing
- Reset (rst low, async): count 0, pointers 0, o_valid 0, o_full 0, o_count 0, o_overflow 0, o_result/o_remainder/o_error 0.
- Load-to-visible latency is 1 cycle. After i_load at edge N, o_valid = 1 and the data appear after edge N. There is no combinational path from i_load to outputs.
- Pop takes effect at the edge where o_valid & i_ready. The next entry (if any) is presented right after that edge.
- o_full and o_count update the cycle after the push/pop that changes them. The producer must sample o_full before issuing i_load.
- Simultaneous push+pop in FULL is legal and lossless. Throughput is 1 result/cycle with i_ready held high.
- If reset is asserted mid-transfer, all entries are discarded and no partial handshake completes.

## Structure
- `pkg_system_mdr` holds DW, `data_in_t`, `result_t`, BUF_DEPTH and a `result_entry_t` packed struct {result, remainder, error}. It also holds the `buf_state_e` enum {EMPTY, ONE, FULL}.
- A single module needs no sub-module. Storage is a 2-element array of `result_entry_t` written in one always_ff block. The count/FSM lives in a second always_ff block with a combinational next-state block.

## Test plan
- Reset then single load: i_load with result 0x0000_1234, remainder 0x0005, error 0, i_ready=0. Required: o_valid=1, o_count=1 next cycle with the same values held. i_ready=1 then gives o_valid=0, o_count=0.
- Fill and backpressure: two loads (0x11, 0x22) with i_ready=0. Required: o_full=1, o_count=2. A third load (0x33) sets o_overflow=1, and the drain order is 0x11 then 0x22, with 0x33 never appearing.
- Full push+pop: while FULL with 0x11/0x22, apply i_load 0x33 and i_ready=1 in the same cycle. Required: o_overflow stays 0, head becomes 0x22, count stays 2, and the drain order is 0x22 then 0x33.
- Streaming: 8 back-to-back loads with i_ready held 1. Required: 8 results out in order at 1/cycle, o_full never asserted, pointer wrap verified.
- Clear priority: with count=2 and overflow=1, assert i_clear together with i_load and i_ready. Required: count=0, o_valid=0, o_overflow=0 next cycle.
- Async reset mid-operation: drop rst while count=1 between clock edges. Required: outputs go to reset values immediately, and after release o_valid=0 until a new load.

Source files
------------

// File: rtl/mdr_result_buffer_pkg.sv
// Shared types for the MDR result buffer: operand/result widths, the buffered
// entry layout and the occupancy state encoding.
package pkg_system_mdr;

    localparam int DW        = 16;
    localparam int BUF_DEPTH = 2;

    typedef logic [DW-1:0]   data_in_t;
    typedef logic [2*DW-1:0] result_t;

    typedef struct packed {
        result_t  result;
        data_in_t remainder;
        logic     error;
    } result_entry_t;

    // Encoding equals occupancy so the state register doubles as the count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/mdr_result_buffer.sv
// Two-entry first-word-fall-through holding buffer for MDR results with
// valid/ready delivery, full backpressure and a sticky overflow flag.
//
// state | meaning
// EMPTY | no entries, o_valid low
// ONE   | one entry at the read pointer
// FULL  | both slots occupied, o_full high
module mdr_result_buffer
    import pkg_system_mdr::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_clear,
    input  logic     i_load,
    input  result_t  i_result,
    input  data_in_t i_remainder,
    input  logic     i_error,
    output logic     o_full,
    output logic     o_valid,
    input  logic     i_ready,
    output result_t  o_result,
    output data_in_t o_remainder,
    output logic     o_error,
    output logic [1:0] o_count,
    output logic     o_overflow
);

    buf_state_e    state_q;
    buf_state_e    state_d;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          overflow_q;
    logic          push;
    logic          pop;
    logic          drop;
    result_entry_t mem [BUF_DEPTH];
    result_entry_t head;

    always_comb begin
        pop     = (state_q != EMPTY) & i_ready;
        push    = i_load & ((state_q != FULL) | pop);
        drop    = i_load & (state_q == FULL) & ~pop;
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop && !push) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (i_clear) begin
            state_q    <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage is zeroed only on reset; a flush leaves stale data behind the pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!i_clear && push) begin
            mem[wr_ptr] <= '{result: i_result, remainder: i_remainder, error: i_error};
        end
    end

    assign head        = mem[rd_ptr];
    assign o_result    = head.result;
    assign o_remainder = head.remainder;
    assign o_error     = head.error;
    assign o_valid     = (state_q != EMPTY);
    assign o_full      = (state_q == FULL);
    assign o_count     = state_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_mdr_result_buffer.sv
// Bench for mdr_result_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mdr_result_buffer;
    import pkg_system_mdr::*;

    logic       clk;
    logic       rst;
    logic       i_clear;
    logic       i_load;
    result_t    i_result;
    data_in_t   i_remainder;
    logic       i_error;
    logic       o_full;
    logic       o_valid;
    logic       i_ready;
    result_t    o_result;
    data_in_t   o_remainder;
    logic       o_error;
    logic [1:0] o_count;
    logic       o_overflow;

    int tests = 0;
    int fails = 0;

    mdr_result_buffer dut (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_load(i_load),
        .i_result(i_result), .i_remainder(i_remainder), .i_error(i_error),
        .o_full(o_full), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_remainder(o_remainder), .o_error(o_error),
        .o_count(o_count), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of at most two entries plus a sticky flag.
    result_entry_t mq[$];
    logic          m_ovf = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (i_clear) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit was_full = (mq.size() == 2);
            automatic bit do_pop   = (mq.size() != 0) && i_ready;
            if (i_load && was_full && !do_pop) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (i_load && (!was_full || do_pop))
                mq.push_back('{result: i_result, remainder: i_remainder, error: i_error});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cmp_valid", 64'(o_valid), 64'(mq.size() != 0));
        check("cmp_count", 64'(o_count), 64'(mq.size()));
        check("cmp_full", 64'(o_full), 64'(mq.size() == 2));
        check("cmp_ovf", 64'(o_overflow), 64'(m_ovf));
        if (mq.size() != 0)
            check("cmp_head", 64'({o_result, o_remainder, o_error}), 64'(mq[0]));
    end

    task automatic drive(input logic ld, input result_t res, input data_in_t rem,
                         input logic err, input logic rdy, input logic clr);
        i_load      = ld;
        i_result    = res;
        i_remainder = rem;
        i_error     = err;
        i_ready     = rdy;
        i_clear     = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic load(input result_t res, input logic rdy);
        drive(1'b1, res, 16'h0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        i_clear = 1'b0; i_load = 1'b0; i_result = '0; i_remainder = '0;
        i_error = 1'b0; i_ready = 1'b0;
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        idle(1'b0);

        // Single load, held, then popped
        drive(1'b1, 32'h0000_1234, 16'h0005, 1'b0, 1'b0, 1'b0);
        check("single_valid", 64'(o_valid), 64'd1);
        check("single_count", 64'(o_count), 64'd1);
        check("single_result", 64'(o_result), 64'h1234);
        check("single_rem", 64'(o_remainder), 64'h5);
        idle(1'b0);
        check("single_hold", 64'(o_result), 64'h1234);
        idle(1'b1);
        check("single_pop_valid", 64'(o_valid), 64'd0);
        check("single_pop_count", 64'(o_count), 64'd0);

        // Fill, overflow, drain
        load(32'h11, 1'b0);
        load(32'h22, 1'b0);
        check("fill_full", 64'(o_full), 64'd1);
        check("fill_count", 64'(o_count), 64'd2);
        load(32'h33, 1'b0);
        check("fill_ovf", 64'(o_overflow), 64'd1);
        check("fill_head", 64'(o_result), 64'h11);
        idle(1'b1);
        check("drain_2nd", 64'(o_result), 64'h22);
        idle(1'b1);
        check("drain_empty", 64'(o_valid), 64'd0);

        // Push+pop while full
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 64'(o_overflow), 64'd0);
        load(32'h11, 1'b0);
        load(32'h22, 1'b0);
        load(32'h33, 1'b1);
        check("pp_ovf", 64'(o_overflow), 64'd0);
        check("pp_head", 64'(o_result), 64'h22);
        check("pp_count", 64'(o_count), 64'd2);
        idle(1'b1);
        check("pp_next", 64'(o_result), 64'h33);
        idle(1'b1);

        // Streaming through both slots
        for (int i = 0; i < 8; i++) begin
            load(32'h100 + 32'(i), 1'b1);
            check("stream_head", 64'(o_result), 64'h100 + 64'(i));
            check("stream_count", 64'(o_count), 64'd1);
        end
        idle(1'b1);

        // Clear beats load and ready
        load(32'hA, 1'b0);
        load(32'hB, 1'b0);
        load(32'hC, 1'b0);
        check("clrp_pre_ovf", 64'(o_overflow), 64'd1);
        drive(1'b1, 32'hD, 16'h0, 1'b0, 1'b1, 1'b1);
        check("clrp_count", 64'(o_count), 64'd0);
        check("clrp_valid", 64'(o_valid), 64'd0);
        check("clrp_ovf", 64'(o_overflow), 64'd0);

        // Async reset between edges
        drive(1'b1, 32'h55, 16'h7, 1'b1, 1'b0, 1'b0);
        i_load = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_result", 64'(o_result), 64'd0);
        check("arst_err", 64'(o_error), 64'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        idle(1'b0);
        idle(1'b1);
        check("arst_after", 64'(o_valid), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 16'($urandom()),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
